// File: rtl/pacman_pio_bank.sv
// rtl/pacman_pio_bank.sv - multi-channel Avalon-MM output PIO bank with frame-synchronised commit (optional irq: PACMAN_PIO_BANK_IRQ_EN)
module pacman_pio_bank #(
    parameter int          CHANNELS        = 4,
    parameter int          WIDTH           = 32,
    parameter logic [31:0] RESET_VALUE     = 32'h0,
    parameter int          FRAME_SYNC_MODE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(CHANNELS)+1:0]   address,
    input  logic                          chipselect,
    input  logic                          write_n,
    input  logic                          read,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    input  logic                          frame_sync,
    output logic [CHANNELS*WIDTH-1:0]     out_port,
`ifdef PACMAN_PIO_BANK_IRQ_EN
    output logic                          irq,
`endif
    output logic [CHANNELS-1:0]           commit_pending
);

    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [WIDTH-1:0]    shadow_new [CHANNELS];
    logic [CHANNELS-1:0] pend_q;
    logic [CHANNELS-1:0] pend_d;
    logic [CHANNELS-1:0] ch_hit;
    logic [CHANNELS-1:0] shadow_wr;
    logic [CHANNELS-1:0] force_c;
    logic [CHANNELS-1:0] frame_c;
    logic [31:0]         readdata_q;
    logic [31:0]         readdata_d;
    logic [31:0]         rd_val;
    logic                frame_sync_q;
    logic [31:0]         ch_sel;
    logic [1:0]          reg_sel;
    logic                in_range;
    logic                wr_en;
    logic                rd_strobe;
    logic                commit_edge;
    logic [WIDTH-1:0]    wd;

    assign ch_sel      = 32'(address) >> 2;
    assign reg_sel     = address[1:0];
    assign in_range    = ch_sel < 32'(CHANNELS);
    assign wr_en       = chipselect & ~write_n & in_range;
    assign rd_strobe   = chipselect & read;
    assign commit_edge = frame_sync & ~frame_sync_q;
    assign wd          = writedata[WIDTH-1:0];

    // Per-channel decode of the single bus access and of the frame commit.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign ch_hit[gi]    = wr_en && (ch_sel == gi);
        assign shadow_wr[gi] = ch_hit[gi] && (reg_sel != 2'd1);
        assign force_c[gi]   = ch_hit[gi] && (reg_sel == 2'd1) && writedata[0];
        assign frame_c[gi]   = commit_edge && pend_q[gi];
        assign shadow_new[gi] = (reg_sel == 2'd2) ? (shadow_q[gi] | wd)  :
                                (reg_sel == 2'd3) ? (shadow_q[gi] & ~wd) : wd;
        assign out_port[gi*WIDTH +: WIDTH] = active_q[gi];
    end

    // Next-state for shadow, active and pending; a commit copies the pre-write shadow.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (FRAME_SYNC_MODE == 0) begin
                if (shadow_wr[i]) begin
                    shadow_d[i] = shadow_new[i];
                    active_d[i] = shadow_new[i];
                end
                pend_d[i] = 1'b0;
            end else begin
                if (frame_c[i] || force_c[i]) begin
                    active_d[i] = shadow_q[i];
                    pend_d[i]   = 1'b0;
                end
                if (shadow_wr[i]) begin
                    shadow_d[i] = shadow_new[i];
                    pend_d[i]   = 1'b1;
                end
            end
        end
    end

`ifdef PACMAN_PIO_BANK_IRQ_EN
    logic irq_q;
    logic irq_d;
    logic irq_set;
    logic irq_clr;

    assign irq_set = (FRAME_SYNC_MODE == 0) ? (|shadow_wr) : (|frame_c);
    assign irq_clr = wr_en && (reg_sel == 2'd1) && writedata[1];

    // Sticky interrupt; a set in the same cycle as a clear keeps it asserted.
    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // Read mux: active for reg 1, shadow otherwise, zero for unmapped channels.
    always_comb begin
        rd_val = '0;
        if (in_range) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_sel == i) begin
                    if (reg_sel == 2'd1) begin
                        rd_val[WIDTH-1:0] = active_q[i];
                    end else begin
                        rd_val[WIDTH-1:0] = shadow_q[i];
                    end
                end
            end
`ifdef PACMAN_PIO_BANK_IRQ_EN
            if ((WIDTH < 32) && (ch_sel == 32'd0) && (reg_sel == 2'd1)) begin
                rd_val[31] = irq_q;
            end
`endif
        end
        readdata_d = rd_strobe ? rd_val : readdata_q;
    end

    // State registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= RST_VAL;
                active_q[i] <= RST_VAL;
            end
            pend_q       <= '0;
            readdata_q   <= '0;
            frame_sync_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            readdata_q   <= readdata_d;
            frame_sync_q <= frame_sync;
        end
    end

    assign readdata       = readdata_q;
    assign commit_pending = pend_q;

endmodule

// File: tb/tb_pacman_pio_bank.sv
// tb/tb_pacman_pio_bank.sv - scoreboard bench for pacman_pio_bank (frame-mode and immediate-mode instances)
module tb_pacman_pio_bank;

    localparam logic [31:0] RV = 32'h00FF_00FF;

    // Signal selectors for scoreboard entries.
    localparam int S_OUT_F = 0, S_OUT_I = 1, S_PEND_F = 2, S_PEND_I = 3,
                   S_IRQ_F = 4, S_IRQ_I = 5, S_RD_F = 6, S_RD_I = 7;

    typedef struct {
        string       name;
        int          sig;
        int          ch;
        logic [31:0] exp;
    } chk_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   address;
    logic         cs_f, cs_i;
    logic         write_n;
    logic         read;
    logic [31:0]  writedata;
    logic         frame_sync;
    logic [31:0]  rd_f, rd_i;
    logic [95:0]  out_f;
    logic [127:0] out_i;
    logic [2:0]   pend_f;
    logic [3:0]   pend_i;
    logic         irq_f, irq_i;

    chk_t chk_q[$];
    chk_t rd_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic rd_v = 1'b0;
    logic rd_sel_f = 1'b0;
    logic done = 1'b0;
    logic done_seen = 1'b0;

    always #5 clk = ~clk;

    pacman_pio_bank #(.CHANNELS(3), .WIDTH(32), .RESET_VALUE(RV), .FRAME_SYNC_MODE(1)) u_frm (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_f), .write_n(write_n),
        .read(read), .writedata(writedata), .readdata(rd_f), .frame_sync(frame_sync),
        .out_port(out_f),
`ifdef PACMAN_PIO_BANK_IRQ_EN
        .irq(irq_f),
`endif
        .commit_pending(pend_f)
    );

    pacman_pio_bank #(.CHANNELS(4), .WIDTH(32), .RESET_VALUE(RV), .FRAME_SYNC_MODE(0)) u_imm (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_i), .write_n(write_n),
        .read(read), .writedata(writedata), .readdata(rd_i), .frame_sync(frame_sync),
        .out_port(out_i),
`ifdef PACMAN_PIO_BANK_IRQ_EN
        .irq(irq_i),
`endif
        .commit_pending(pend_i)
    );

`ifndef PACMAN_PIO_BANK_IRQ_EN
    assign irq_f = 1'b0;
    assign irq_i = 1'b0;
`endif

    function automatic logic [31:0] get_act(int sig, int ch);
        case (sig)
            S_OUT_F:  return out_f[ch*32 +: 32];
            S_OUT_I:  return out_i[ch*32 +: 32];
            S_PEND_F: return {29'd0, pend_f};
            S_PEND_I: return {28'd0, pend_i};
            S_IRQ_F:  return {31'd0, irq_f};
            S_IRQ_I:  return {31'd0, irq_i};
            S_RD_F:   return rd_f;
            default:  return rd_i;
        endcase
    endfunction

    // Records which instance a read strobe targeted so the monitor knows when readdata is due.
    always @(posedge clk) begin
        rd_v     <= read & (cs_f | cs_i);
        rd_sel_f <= cs_f;
    end

    // Monitor: pops and compares expectations away from the active edge.
    always @(negedge clk) begin
        chk_t e;
        logic [31:0] act;
        if (rd_v) begin
            vectors++;
            if (rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_underflow: read data presented with no expectation queued");
            end else begin
                e = rd_q.pop_front();
                act = rd_sel_f ? rd_f : rd_i;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
        while (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            act = get_act(e.sig, e.ch);
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
        if (done && !done_seen) begin
            done_seen <= 1'b1;
            vectors++;
            if (rd_q.size() != 0) begin
                miscompares++;
                $display("FAIL rd_leftover: %0d reads never answered, expected 0", rd_q.size());
            end
        end
    end

    task automatic expect_sig(input string name, input int sig, input int ch, input logic [31:0] exp);
        chk_t e;
        e.name = name; e.sig = sig; e.ch = ch; e.exp = exp;
        chk_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input bit frm, input int ch, input int rg, input logic [31:0] data);
        address   = 4'((ch << 2) | rg);
        writedata = data;
        write_n   = 1'b0;
        cs_f      = frm;
        cs_i      = ~frm;
        cyc();
        write_n   = 1'b1;
        cs_f      = 1'b0;
        cs_i      = 1'b0;
    endtask

    task automatic bus_read(input bit frm, input int ch, input int rg, input logic [31:0] exp, input string name);
        chk_t e;
        e.name = name; e.sig = frm ? S_RD_F : S_RD_I; e.ch = ch; e.exp = exp;
        rd_q.push_back(e);
        address = 4'((ch << 2) | rg);
        read    = 1'b1;
        cs_f    = frm;
        cs_i    = ~frm;
        cyc();
        read    = 1'b0;
        cs_f    = 1'b0;
        cs_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; address = '0; cs_f = 1'b0; cs_i = 1'b0; write_n = 1'b1;
        read = 1'b0; writedata = '0; frame_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        for (int c = 0; c < 3; c++) expect_sig("rst_out_frm", S_OUT_F, c, RV);
        for (int c = 0; c < 4; c++) expect_sig("rst_out_imm", S_OUT_I, c, RV);
        expect_sig("rst_pend_frm", S_PEND_F, 0, 32'd0);
        expect_sig("rst_pend_imm", S_PEND_I, 0, 32'd0);
        expect_sig("rst_rd_frm", S_RD_F, 0, 32'd0);
        expect_sig("rst_rd_imm", S_RD_I, 0, 32'd0);
        expect_sig("rst_irq_frm", S_IRQ_F, 0, 32'd0);
        cyc();

        // Immediate mode
        bus_write(1'b0, 2, 0, 32'hDEAD_BEEF);
        expect_sig("imm_out_ch2", S_OUT_I, 2, 32'hDEAD_BEEF);
        expect_sig("imm_out_ch1", S_OUT_I, 1, RV);
        expect_sig("imm_pend", S_PEND_I, 0, 32'd0);
`ifdef PACMAN_PIO_BANK_IRQ_EN
        expect_sig("imm_irq_on_write", S_IRQ_I, 0, 32'd1);
`endif
        bus_read(1'b0, 2, 1, 32'hDEAD_BEEF, "imm_rd_active");
        bus_write(1'b0, 2, 2, 32'h0000_0010);
        expect_sig("imm_outset", S_OUT_I, 2, 32'hDEAD_BEFF);
        bus_write(1'b0, 2, 3, 32'hF000_0000);
        expect_sig("imm_outclr", S_OUT_I, 2, 32'h0EAD_BEFF);

        // Frame mode: write is held until the frame_sync rise
        bus_write(1'b1, 1, 0, 32'h0000_1234);
        expect_sig("frm_hold_out", S_OUT_F, 1, RV);
        expect_sig("frm_hold_pend", S_PEND_F, 0, 32'b010);
        frame_sync = 1'b1;
        cyc();
        expect_sig("frm_commit_out", S_OUT_F, 1, 32'h0000_1234);
        expect_sig("frm_commit_pend", S_PEND_F, 0, 32'b000);
`ifdef PACMAN_PIO_BANK_IRQ_EN
        expect_sig("frm_irq_set", S_IRQ_F, 0, 32'd1);
`endif
        bus_write(1'b1, 1, 0, 32'h0000_5678);
        expect_sig("frm_single_out", S_OUT_F, 1, 32'h0000_1234);
        expect_sig("frm_single_pend", S_PEND_F, 0, 32'b010);
        cyc();
        expect_sig("frm_level_out", S_OUT_F, 1, 32'h0000_1234);
        frame_sync = 1'b0;
        cyc();
        bus_write(1'b1, 0, 1, 32'h0000_0002);
`ifdef PACMAN_PIO_BANK_IRQ_EN
        expect_sig("frm_irq_clr", S_IRQ_F, 0, 32'd0);
`endif
        expect_sig("irqclr_no_commit", S_OUT_F, 0, RV);

        // Set/clear and force commit on channel 2
        bus_write(1'b1, 2, 0, 32'h0000_00F0);
        bus_write(1'b1, 2, 2, 32'h0000_000F);
        bus_read(1'b1, 2, 2, 32'h0000_00FF, "set_rd_shadow");
        bus_write(1'b1, 2, 3, 32'h0000_00F0);
        bus_read(1'b1, 2, 0, 32'h0000_000F, "clr_rd_shadow");
        expect_sig("setclr_out_held", S_OUT_F, 2, RV);
        bus_write(1'b1, 2, 1, 32'h0000_0001);
        expect_sig("force_out", S_OUT_F, 2, 32'h0000_000F);
        expect_sig("force_pend", S_PEND_F, 0, 32'b010);
`ifdef PACMAN_PIO_BANK_IRQ_EN
        expect_sig("force_no_irq", S_IRQ_F, 0, 32'd0);
`endif
        bus_read(1'b1, 2, 1, 32'h0000_000F, "force_rd_active");

        // Collision of a shadow write with the frame_sync rise
        bus_write(1'b1, 0, 0, 32'h0000_0005);
        expect_sig("coll_pre_pend", S_PEND_F, 0, 32'b011);
        frame_sync = 1'b1;
        bus_write(1'b1, 0, 0, 32'h0000_000A);
        expect_sig("coll_active", S_OUT_F, 0, 32'h0000_0005);
        expect_sig("coll_other_ch", S_OUT_F, 1, 32'h0000_5678);
        expect_sig("coll_pend", S_PEND_F, 0, 32'b001);
        bus_read(1'b1, 0, 0, 32'h0000_000A, "coll_rd_shadow");
        frame_sync = 1'b0;
        cyc();
        frame_sync = 1'b1;
        cyc();
        expect_sig("coll_next_frame", S_OUT_F, 0, 32'h0000_000A);
        expect_sig("coll_next_pend", S_PEND_F, 0, 32'b000);
        frame_sync = 1'b0;
        cyc();

        // Clear in the same cycle as a frame commit
        bus_write(1'b1, 0, 1, 32'h0000_0002);
`ifdef PACMAN_PIO_BANK_IRQ_EN
        expect_sig("irq_clr2", S_IRQ_F, 0, 32'd0);
`endif
        bus_write(1'b1, 2, 0, 32'h0000_0001);
        frame_sync = 1'b1;
        bus_write(1'b1, 0, 1, 32'h0000_0002);
        expect_sig("setclr_out", S_OUT_F, 2, 32'h0000_0001);
        expect_sig("setclr_pend", S_PEND_F, 0, 32'b000);
`ifdef PACMAN_PIO_BANK_IRQ_EN
        expect_sig("irq_set_wins", S_IRQ_F, 0, 32'd1);
`endif
        frame_sync = 1'b0;
        cyc();

        // Same-value write still pends; out-of-range channel is inert
        bus_write(1'b1, 0, 0, 32'h0000_000A);
        expect_sig("nochange_pend", S_PEND_F, 0, 32'b001);
        bus_write(1'b1, 3, 0, 32'h0000_FFFF);
        expect_sig("oor_pend", S_PEND_F, 0, 32'b001);
        expect_sig("oor_out2", S_OUT_F, 2, 32'h0000_0001);
        bus_read(1'b1, 3, 0, 32'h0000_0000, "oor_rd_reg0");
        bus_read(1'b1, 3, 1, 32'h0000_0000, "oor_rd_reg1");
        bus_read(1'b1, 1, 1, 32'h0000_5678, "rd_active_ch1");

        repeat (2) cyc();
        done = 1'b1;
        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
